// File: rtl/ctrl_sequencer.sv
// Frame sequencer for a two-row pixel readout: erase while idle, expose for a
// clamped number of cycles, then an 8-step readout of row 1 and row 2.
module ctrl_sequencer #(
    parameter int EX_MIN = 2,
    parameter int EX_MAX = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       exp_start,
    input  logic [4:0] init,
    output logic       erase,
    output logic       expose,
    output logic       nre_1,
    output logic       nre_2,
    output logic       adc,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXPOSURE = 2'd1,
        READOUT  = 2'd2
    } state_t;

    localparam logic [4:0] MIN_N = 5'(EX_MIN);
    localparam logic [4:0] MAX_N = 5'(EX_MAX);

    state_t     state = IDLE;
    state_t     state_n;
    logic [4:0] exp_cnt;
    logic [4:0] exp_cnt_n;
    logic [2:0] step;
    logic [2:0] step_n;
    logic [4:0] init_clamped;

    always_comb begin
        if (init < MIN_N)
            init_clamped = MIN_N;
        else if (init > MAX_N)
            init_clamped = MAX_N;
        else
            init_clamped = init;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            exp_cnt <= 5'd0;
            step    <= 3'd0;
        end else begin
            state   <= state_n;
            exp_cnt <= exp_cnt_n;
            step    <= step_n;
        end
    end

    // exp_cnt holds the exposure cycles remaining, including the current one.
    always_comb begin
        state_n   = state;
        exp_cnt_n = exp_cnt;
        step_n    = step;
        case (state)
            IDLE: begin
                if (exp_start) begin
                    state_n   = EXPOSURE;
                    exp_cnt_n = init_clamped;
                end
            end
            EXPOSURE: begin
                if (exp_cnt <= 5'd1) begin
                    state_n   = READOUT;
                    exp_cnt_n = 5'd0;
                    step_n    = 3'd0;
                end else begin
                    exp_cnt_n = exp_cnt - 5'd1;
                end
            end
            READOUT: begin
                if (step == 3'd7) begin
                    state_n = IDLE;
                    step_n  = 3'd0;
                end else begin
                    step_n = step + 3'd1;
                end
            end
            default: begin
                state_n   = IDLE;
                exp_cnt_n = 5'd0;
                step_n    = 3'd0;
            end
        endcase
    end

    always_comb begin
        erase  = 1'b0;
        expose = 1'b0;
        nre_1  = 1'b1;
        nre_2  = 1'b1;
        adc    = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (state)
            IDLE: begin
                erase = 1'b1;
                busy  = 1'b0;
            end
            EXPOSURE: expose = 1'b1;
            READOUT: begin
                // Each row gets two read-enable cycles, converting in the second.
                case (step)
                    3'd0: nre_1 = 1'b0;
                    3'd1: begin
                        nre_1 = 1'b0;
                        adc   = 1'b1;
                    end
                    3'd4: nre_2 = 1'b0;
                    3'd5: begin
                        nre_2 = 1'b0;
                        adc   = 1'b1;
                    end
                    3'd7: done = 1'b1;
                    default: ;
                endcase
            end
            default: begin
                erase = 1'b1;
                busy  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: checks every output cycle by cycle
// against hand-written exposure/readout vectors.
module tb_ctrl_sequencer;

    logic       clk;
    logic       reset;
    logic       exp_start;
    logic [4:0] init;
    logic       erase;
    logic       expose;
    logic       nre_1;
    logic       nre_2;
    logic       adc;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    // Output vector order: {erase, expose, nre_1, nre_2, adc, busy, done}
    localparam logic [6:0] V_IDLE   = 7'b1011000;
    localparam logic [6:0] V_EXPOSE = 7'b0111010;

    ctrl_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .exp_start (exp_start),
        .init      (init),
        .erase     (erase),
        .expose    (expose),
        .nre_1     (nre_1),
        .nre_2     (nre_2),
        .adc       (adc),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {erase, expose, nre_1, nre_2, adc, busy, done};
    endfunction

    function automatic logic [6:0] readout_vec(input int s);
        case (s)
            0:       return 7'b0001010;
            1:       return 7'b0001110;
            4:       return 7'b0010010;
            5:       return 7'b0010110;
            7:       return 7'b0011011;
            default: return 7'b0011010;
        endcase
    endfunction

    function automatic logic [6:0] frame_vec(input int i, input int n);
        if (i < n)
            return V_EXPOSE;
        return readout_vec(i - n);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Pulses exp_start once, then checks the frame cycle by cycle. Optionally
    // changes init at cycle chg_at and re-pulses exp_start at cycle pulse_at.
    task automatic run_frame(input string tag, input logic [4:0] init_v, input int n,
                             input int chg_at, input logic [4:0] chg_v, input int pulse_at);
        int busy_cnt;
        int exp_cnt;
        busy_cnt = 0;
        exp_cnt  = 0;
        @(negedge clk);
        init      = init_v;
        exp_start = 1'b1;
        @(negedge clk);
        exp_start = 1'b0;
        for (int i = 0; i < n + 8; i++) begin
            if (i > 0) begin
                @(negedge clk);
                exp_start = 1'b0;
            end
            check_eq($sformatf("%s cyc%0d", tag, i), 32'(outs()), 32'(frame_vec(i, n)));
            busy_cnt += int'(busy);
            exp_cnt  += int'(expose);
            if (i == chg_at)   init = chg_v;
            if (i == pulse_at) exp_start = 1'b1;
        end
        @(negedge clk);
        exp_start = 1'b0;
        check_eq({tag, " idle after"}, 32'(outs()), 32'(V_IDLE));
        check_eq({tag, " busy len"}, 32'(busy_cnt), 32'(n + 8));
        check_eq({tag, " expose len"}, 32'(exp_cnt), 32'(n));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        exp_start = 1'b0;
        init      = 5'd0;

        // Reset held low for two cycles
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq($sformatf("reset cyc%0d", i), 32'(outs()), 32'(V_IDLE));
        end
        reset = 1'b1;
        @(negedge clk);
        check_eq("idle after reset", 32'(outs()), 32'(V_IDLE));

        // Nominal frame and clamp boundaries
        run_frame("init16", 5'd16, 16, -1, 5'd0, -1);
        run_frame("init0",  5'd0,  2,  -1, 5'd0, -1);
        run_frame("init31", 5'd31, 30, -1, 5'd0, -1);
        run_frame("init2",  5'd2,  2,  -1, 5'd0, -1);
        run_frame("init30", 5'd30, 30, -1, 5'd0, -1);
        run_frame("init1",  5'd1,  2,  -1, 5'd0, -1);

        // init changes mid-exposure and a request during readout are ignored
        run_frame("latch5", 5'd5, 5, 2, 5'd20, 5 + 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("no extra frame %0d", i), 32'(outs()), 32'(V_IDLE));
        end

        // exp_start held: back-to-back frames with one idle cycle between
        @(negedge clk);
        init      = 5'd4;
        exp_start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            int busy_cnt;
            busy_cnt = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                check_eq($sformatf("b2b f%0d cyc%0d", f, i), 32'(outs()), 32'(frame_vec(i, 4)));
                busy_cnt += int'(busy);
            end
            check_eq($sformatf("b2b f%0d busy len", f), 32'(busy_cnt), 32'd12);
            @(negedge clk);
            check_eq($sformatf("b2b gap %0d", f), 32'(outs()), 32'(V_IDLE));
        end
        exp_start = 1'b0;
        @(negedge clk);
        check_eq("b2b stop", 32'(outs()), 32'(V_IDLE));

        // Reset during exposure cycle 3
        init      = 5'd8;
        exp_start = 1'b1;
        @(negedge clk);
        exp_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check_eq($sformatf("rst_exp cyc%0d", i), 32'(outs()), 32'(V_EXPOSE));
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_eq("rst_exp idle", 32'(outs()), 32'(V_IDLE));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("rst_exp abandon %0d", i), 32'(outs()), 32'(V_IDLE));
        end

        // Reset during readout step 1
        init      = 5'd2;
        exp_start = 1'b1;
        @(negedge clk);
        exp_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check_eq($sformatf("rst_rd cyc%0d", i), 32'(outs()), 32'(frame_vec(i, 2)));
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_eq("rst_rd idle", 32'(outs()), 32'(V_IDLE));
        check_eq("rst_rd nre_1", 32'(nre_1), 32'd1);
        check_eq("rst_rd adc", 32'(adc), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("rst_rd abandon %0d", i), 32'(outs()), 32'(V_IDLE));
        end

        // A fresh frame after reset still works
        run_frame("after_rst", 5'd3, 3, -1, 5'd0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Backstop so the bench cannot run away
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
